jt12_i2s_tx: RTL and testbench

- Consumer end of the jt12 PCM mixer output.
- Takes 16-bit signed left/right samples, each qualified by a one-cycle strobe, and serialises them as a standard Philips I2S stream (bclk, lrck, sdata) for an external audio DAC.
- Double-buffered: a holding register accepts the next sample while the current frame shifts out.
- Sits at top level between the mixer and the board codec pins.

---
 rtl/jt12_i2s_pkg.sv | 15 +
 rtl/jt12_i2s_clkgen.sv | 40 ++++
 rtl/jt12_i2s_tx.sv | 135 +++++++++++++
 tb/tb_jt12_i2s_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_i2s_pkg.sv
// jt12_i2s_pkg: shared constants for the jt12 I2S transmitter.
// PCM width, lrck slot encoding and a frame-length helper (clk cycles).
package jt12_i2s_pkg;

   localparam int   PCM_W      = 16;
   localparam logic LRCK_LEFT  = 1'b0;
   localparam logic LRCK_RIGHT = 1'b1;

   // clk cycles per stereo frame: two slots, two bclk halves per bit
   function automatic int frame_len(input int slot_bits,
                                    input int bclk_half);
      return 4 * slot_bits * bclk_half;
   endfunction

endpackage

// File: rtl/jt12_i2s_clkgen.sv
// jt12_i2s_clkgen: bclk divider for the I2S transmitter.
// Ports: clk, rst (async high) -> bclk, fall (1-clk strobe as bclk drops).
module jt12_i2s_clkgen
   import jt12_i2s_pkg::*;
#(
   parameter int BCLK_HALF = 8
) (
   input  logic clk,
   input  logic rst,
   output logic bclk,
   output logic fall
);

   localparam int D_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

   logic [D_W-1:0] div_cnt_q, div_cnt_d;
   logic           bclk_q, bclk_d;
   logic           term;

   always_comb begin
      term      = (div_cnt_q == D_W'(BCLK_HALF - 1));
      div_cnt_d = term ? '0 : div_cnt_q + 1'b1;
      bclk_d    = term ? ~bclk_q : bclk_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= '0;
         bclk_q    <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         bclk_q    <= bclk_d;
      end
   end

   // Combinational so frame state updates on the same edge bclk drops
   assign fall = term & bclk_q;
   assign bclk = bclk_q;

endmodule

// File: rtl/jt12_i2s_tx.sv
// jt12_i2s_tx: double-buffered Philips I2S serialiser for jt12 PCM output.
// Ports: clk, rst, sample, left_in, right_in -> bclk, lrck, sdata.
// Option JT12_I2S_OVR_EN adds ovr_clr (in) and ovr (sticky overwrite flag).
module jt12_i2s_tx
   import jt12_i2s_pkg::*;
#(
   parameter int BCLK_HALF = 8,
   parameter int SLOT_BITS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample,
   input  logic [PCM_W-1:0] left_in,
   input  logic [PCM_W-1:0] right_in,
   output logic             bclk,
   output logic             lrck,
   output logic             sdata
`ifdef JT12_I2S_OVR_EN
   ,
   input  logic             ovr_clr,
   output logic             ovr
`endif
);

   localparam int F_W    = 2 * SLOT_BITS;
   localparam int P_W    = $clog2(F_W);
   localparam int P_LAST = F_W - 1;

   logic             fall;
   logic             load;
   logic [P_W-1:0]   p_q, p_d, p_next;
   logic             lrck_q, lrck_d;
   logic             sdata_q, sdata_d;
   logic [F_W-1:0]   f_q, f_d;
   logic [PCM_W-1:0] hold_l_q, hold_l_d;
   logic [PCM_W-1:0] hold_r_q, hold_r_d;
   logic             pending_q, pending_d;

   // {L, pad, R, pad}; pad bits are zero
   function automatic logic [F_W-1:0] build(input logic [PCM_W-1:0] l,
                                            input logic [PCM_W-1:0] r);
      return (F_W'(l) << (F_W - PCM_W)) |
             (F_W'(r) << (SLOT_BITS - PCM_W));
   endfunction

   jt12_i2s_clkgen #(
      .BCLK_HALF (BCLK_HALF)
   ) u_clkgen (
      .clk  (clk),
      .rst  (rst),
      .bclk (bclk),
      .fall (fall)
   );

   always_comb begin
      p_next    = (p_q == P_W'(P_LAST)) ? '0 : p_q + 1'b1;
      load      = fall && (p_next == '0);
      p_d       = p_q;
      lrck_d    = lrck_q;
      sdata_d   = sdata_q;
      f_d       = f_q;
      hold_l_d  = hold_l_q;
      hold_r_d  = hold_r_q;
      pending_d = pending_q;

      if (sample) begin
         hold_l_d = left_in;
         hold_r_d = right_in;
      end

      if (fall) begin
         p_d     = p_next;
         lrck_d  = (p_next >= P_W'(SLOT_BITS)) ? LRCK_RIGHT : LRCK_LEFT;
         // old MSB gives the one-bclk I2S delay after lrck moves
         sdata_d = f_q[F_W-1];
         if (load)
            f_d = sample ? build(left_in, right_in)
                         : build(hold_l_q, hold_r_q);
         else
            f_d = {f_q[F_W-2:0], 1'b0};
      end

      // a sample on the load fall bypasses into F, so nothing is left pending
      if (load)
         pending_d = 1'b0;
      else if (sample)
         pending_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q       <= P_W'(P_LAST);
         lrck_q    <= LRCK_RIGHT;
         sdata_q   <= 1'b0;
         f_q       <= '0;
         hold_l_q  <= '0;
         hold_r_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         p_q       <= p_d;
         lrck_q    <= lrck_d;
         sdata_q   <= sdata_d;
         f_q       <= f_d;
         hold_l_q  <= hold_l_d;
         hold_r_q  <= hold_r_d;
         pending_q <= pending_d;
      end
   end

   assign lrck  = lrck_q;
   assign sdata = sdata_q;

`ifdef JT12_I2S_OVR_EN
   logic ovr_q, ovr_d;

   // set wins over clear
   always_comb begin
      ovr_d = ovr_q;
      if (ovr_clr)
         ovr_d = 1'b0;
      if (sample && pending_q)
         ovr_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovr_q <= 1'b0;
      else
         ovr_q <= ovr_d;
   end

   assign ovr = ovr_q;
`endif

endmodule

// File: tb/tb_jt12_i2s_tx.sv
// tb_jt12_i2s_tx: directed bench for jt12_i2s_tx, BCLK_HALF=2,
// SLOT_BITS=16 and SLOT_BITS=24 instances driven from shared inputs.
module tb_jt12_i2s_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sample = 1'b0;
   logic [15:0] left_in = '0;
   logic [15:0] right_in = '0;
   logic        bclk16, lrck16, sdata16;
   logic        bclk24, lrck24, sdata24;
`ifdef JT12_I2S_OVR_EN
   logic        ovr_clr = 1'b0;
   logic        ovr16, ovr24;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   int          tc = 0;
   logic [63:0] sh16 = '0;
   logic [63:0] sh24 = '0;

   always #5 clk = ~clk;

   jt12_i2s_tx #(
      .BCLK_HALF (2),
      .SLOT_BITS (16)
   ) dut16 (
      .clk      (clk),
      .rst      (rst),
      .sample   (sample),
      .left_in  (left_in),
      .right_in (right_in),
      .bclk     (bclk16),
      .lrck     (lrck16),
      .sdata    (sdata16)
`ifdef JT12_I2S_OVR_EN
      ,
      .ovr_clr  (ovr_clr),
      .ovr      (ovr16)
`endif
   );

   jt12_i2s_tx #(
      .BCLK_HALF (2),
      .SLOT_BITS (24)
   ) dut24 (
      .clk      (clk),
      .rst      (rst),
      .sample   (sample),
      .left_in  (left_in),
      .right_in (right_in),
      .bclk     (bclk24),
      .lrck     (lrck24),
      .sdata    (sdata24)
`ifdef JT12_I2S_OVR_EN
      ,
      .ovr_clr  (ovr_clr),
      .ovr      (ovr24)
`endif
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // one clk; every 4th clk after reset release is a bclk fall
   task automatic tick();
      @(posedge clk);
      #1;
      tc++;
      if (tc % 4 == 0) begin
         sh16 = {sh16[62:0], sdata16};
         sh24 = {sh24[62:0], sdata24};
      end
   endtask

   task automatic run_until(input int t);
      while (tc < t) tick();
   endtask

   task automatic pulse(input logic [15:0] l, input logic [15:0] r);
      left_in  = l;
      right_in = r;
      sample   = 1'b1;
      tick();
      sample   = 1'b0;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      sample = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_bclk16", bclk16, 1'b0);
      check("rst_lrck16", lrck16, 1'b1);
      check("rst_sdata16", sdata16, 1'b0);
      check("rst_lrck24", lrck24, 1'b1);
`ifdef JT12_I2S_OVR_EN
      check("rst_ovr16", ovr16, 1'b0);
`endif
      rst  = 1'b0;
      tc   = 0;
      sh16 = '0;
      sh24 = '0;
   endtask

   task automatic check_startup();
      logic [7:0] bexp;
      bexp = 8'b0110_0110;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("start_bclk", bclk16, bexp[i-1]);
         if (i == 4)
            check("start_lrck", lrck16, 1'b0);
      end
   endtask

   initial begin
      // idle frame: timing, lrck slots, silent data
      do_reset();
      check_startup();
      run_until(67);
      check("t1_lrck_p15", lrck16, 1'b0);
      run_until(68);
      check("t1_lrck_p16", lrck16, 1'b1);
      run_until(131);
      check("t1_lrck_p31", lrck16, 1'b1);
      run_until(132);
      check("t1_lrck_p0", lrck16, 1'b0);
      check("t1_frame", sh16[31:0], 32'h0);

      // sample before first fall, then re-sent unchanged
      do_reset();
      pulse(16'h8001, 16'h7FFE);
      run_until(132);
      check("t2_p0_first", sh16[32], 1'b0);
      check("t2_left", sh16[31:16], 16'h8001);
      check("t2_right", sh16[15:0], 16'h7FFE);
      run_until(260);
      check("t2_hold", sh16[31:0], 32'h8001_7FFE);

      // sample on the load fall takes the bypass
      run_until(387);
      pulse(16'hA5A5, 16'h5A5A);
      check("t3_pending", dut16.pending_q, 1'b0);
`ifdef JT12_I2S_OVR_EN
      check("t3_ovr", ovr16, 1'b0);
`endif
      run_until(516);
      check("t3_frame", sh16[31:0], 32'hA5A5_5A5A);

      // two samples in one frame: newest wins
      run_until(517);
      pulse(16'h1111, 16'h0F0F);
      check("t4_pending", dut16.pending_q, 1'b1);
      run_until(530);
      pulse(16'h2222, 16'h3333);
`ifdef JT12_I2S_OVR_EN
      check("t4_ovr_set", ovr16, 1'b1);
`endif
      run_until(644);
      check("t4_cur_frame", sh16[31:0], 32'hA5A5_5A5A);
      check("t4_pend_clr", dut16.pending_q, 1'b0);
      run_until(772);
      check("t4_new_frame", sh16[31:0], 32'h2222_3333);
`ifdef JT12_I2S_OVR_EN
      check("t4_ovr_held", ovr16, 1'b1);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      check("t4_ovr_clr", ovr16, 1'b0);
`endif

      // 24-bit slots with zero padding
      do_reset();
      pulse(16'hFFFF, 16'h8000);
      run_until(99);
      check("t5_lrck_p23", lrck24, 1'b0);
      run_until(100);
      check("t5_lrck_p24", lrck24, 1'b1);
      run_until(195);
      check("t5_lrck_p47", lrck24, 1'b1);
      run_until(196);
      check("t5_lrck_p0", lrck24, 1'b0);
      check("t5_frame", sh24[47:0],
            {16'hFFFF, 8'h00, 16'h8000, 8'h00});

      // reset in the right slot of the 16-bit instance
      run_until(202);
      check("t6_pre_bclk", bclk16, 1'b1);
      check("t6_pre_lrck", lrck16, 1'b1);
      check("t6_pre_sdata", sdata16, 1'b1);
      rst = 1'b1;
      #1;
      check("t6_async_bclk", bclk16, 1'b0);
      check("t6_async_lrck", lrck16, 1'b1);
      check("t6_async_sdata", sdata16, 1'b0);
      do_reset();
      check_startup();
      run_until(132);
      check("t6_frame", sh16[31:0], 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

endmodule
